branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//   Parametrised, pipelined successor to the combinational branch compare decode.
//   Takes a decoded branch op plus operands from the execute stage, evaluates the condition
//   (signed), computes the next PC and flags a misprediction against the fetch-stage guess.
//   One registered stage with a valid/ready handshake sits between execute and the PC/flush
//   logic. Saturating statistics counters track branches and mispredicts.
// PARAMETERS
//   DATA_W   32  operand width (rs/rt), two's complement
//   ADDR_W   32  PC/target width; all PC arithmetic wraps modulo 2**ADDR_W
//   CNT_W    16  width of statistics counters (saturating)
//   PC_INC   4   sequential PC increment
// PORTS
//   clk              in   1       clock, rising edge
//   rst              in   1       asynchronous reset, active-high
//   in_valid         in   1       input op valid
//   in_ready         out  1       block can accept input this cycle
//   in_op            in   5       branch op code
//   in_rs            in   DATA_W  first operand
//   in_rt            in   DATA_W  second operand (BEQ/BNE only)
//   in_pc            in   ADDR_W  PC of the branch
//   in_offset        in   ADDR_W  byte offset, already sign-extended and shifted
//   in_pred_taken    in   1       fetch-stage prediction
//   flush            in   1       kill in-flight and incoming op
//   out_valid        out  1       result valid
//   out_ready        in   1       consumer accepts result
//   out_branch       out  1       op was a recognised branch
//   out_taken        out  1       condition true
//   out_target       out  ADDR_W  resolved next PC
//   out_mispredict   out  1       out_branch && (out_taken != prediction)
//   cnt_branches     out  CNT_W   accepted branch ops
//   cnt_mispredicts  out  CNT_W   accepted mispredicted branch ops
// BEHAVIOUR
//   - Ops: 00110 BEQ rs==rt; 00111 BNE rs!=rt; 01000 BLEZ rs<=0; 01001 BGTZ rs>0;
//     01010 BGEZ rs>=0; 01011 BLTZ rs<0. Zero compares are signed (MSB = sign).
//   - Any other op: accepted normally, out_branch=0, out_taken=0, out_mispredict=0,
//     out_target=in_pc+PC_INC, counters unchanged.
//   - Target: taken ? in_pc+PC_INC+in_offset : in_pc+PC_INC, truncated to ADDR_W.
//   - Handshake: in_ready = !flush && (!out_valid || out_ready). Transfer on in_valid&&in_ready.
//     Latency 1: accepted op appears on out_* the next cycle with out_valid=1.
//   - Output held stable while out_valid && !out_ready; out_valid drops after out_ready
//     only if no new transfer that cycle (back-to-back throughput 1/cycle).
//   - States: EMPTY (out_valid=0) -> FULL on transfer; FULL -> EMPTY on out_ready with no
//     transfer; FULL -> FULL on out_ready with transfer or on stall.
//   - flush: out_valid=0 next cycle regardless of out_ready; input that cycle not accepted
//     (in_ready=0); out_* data regs may keep stale values. Counters are not rolled back.
//   - Counters update at input transfer: cnt_branches+=1 for recognised branch,
//     cnt_mispredicts+=1 if also mispredicted; both saturate at 2**CNT_W-1, never wrap.
//   - Reset (async, any time incl. mid-stall): out_valid, out_branch, out_taken,
//     out_mispredict, out_target, cnt_branches, cnt_mispredicts all 0; held op discarded.
//     in_ready=1 during/after reset unless flush.
// TESTING
//   1. BEQ rs=rt=5, pc=0x100, off=0x20, pred=0 -> next cycle taken=1, target=0x124,
//      mispredict=1, cnt_branches=1, cnt_mispredicts=1.
//   2. BGEZ rs=0x80000000 / BLEZ rs=0 / BGTZ rs=0 / BLTZ rs=0xFFFFFFFF -> taken 0/1/0/1.
//   3. Op 00000 pc=0xFFFFFFFC -> out_branch=0, target=0x00000000 (wrap), counters unchanged.
//   4. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable; release ->
//      held result consumed, next op appears following cycle, none lost or duplicated.
//   5. flush while FULL and in_valid=1 -> out_valid=0 next cycle, input not accepted.
//   6. CNT_W=4, 20 mispredicted branches -> both counters stop at 15; assert rst mid-stall
//      -> all outputs 0 immediately, out_valid=0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolve stage: signed condition evaluation, next-PC and mispredict flag behind one
// registered valid/ready slot, plus saturating branch/mispredict statistics.
module branch_resolve_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned PC_INC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic [ADDR_W-1:0] in_offset,
  input  logic              in_pred_taken,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_branch,
  output logic              out_taken,
  output logic [ADDR_W-1:0] out_target,
  output logic              out_mispredict,
  output logic [CNT_W-1:0]  cnt_branches,
  output logic [CNT_W-1:0]  cnt_mispredicts
);

  localparam logic [4:0] OpBeq  = 5'b00110;
  localparam logic [4:0] OpBne  = 5'b00111;
  localparam logic [4:0] OpBlez = 5'b01000;
  localparam logic [4:0] OpBgtz = 5'b01001;
  localparam logic [4:0] OpBgez = 5'b01010;
  localparam logic [4:0] OpBltz = 5'b01011;

  localparam logic [ADDR_W-1:0] PcInc  = ADDR_W'(PC_INC);
  localparam logic [CNT_W-1:0]  CntMax = '1;
  localparam logic [CNT_W-1:0]  CntOne = CNT_W'(1);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e state_q, state_d;

  logic              xfer;
  logic              rs_neg, rs_zero;
  logic              dec_branch, dec_taken, dec_mispredict;
  logic [ADDR_W-1:0] seq_pc, dec_target;

  logic              branch_q, taken_q, mispredict_q;
  logic [ADDR_W-1:0] target_q;
  logic [CNT_W-1:0]  cnt_br_q, cnt_br_d;
  logic [CNT_W-1:0]  cnt_mp_q, cnt_mp_d;

  assign out_valid = (state_q == StFull);
  assign in_ready  = !flush && (!out_valid || out_ready);
  assign xfer      = in_valid && in_ready;

  // Zero compares use the sign bit directly rather than a full signed comparator.
  assign rs_neg  = in_rs[DATA_W-1];
  assign rs_zero = (in_rs == '0);

  always_comb begin
    dec_branch = 1'b0;
    dec_taken  = 1'b0;
    case (in_op)
      OpBeq: begin
        dec_branch = 1'b1;
        dec_taken  = (in_rs == in_rt);
      end
      OpBne: begin
        dec_branch = 1'b1;
        dec_taken  = (in_rs != in_rt);
      end
      OpBlez: begin
        dec_branch = 1'b1;
        dec_taken  = rs_neg || rs_zero;
      end
      OpBgtz: begin
        dec_branch = 1'b1;
        dec_taken  = !rs_neg && !rs_zero;
      end
      OpBgez: begin
        dec_branch = 1'b1;
        dec_taken  = !rs_neg;
      end
      OpBltz: begin
        dec_branch = 1'b1;
        dec_taken  = rs_neg;
      end
      default: begin
        dec_branch = 1'b0;
        dec_taken  = 1'b0;
      end
    endcase
  end

  assign seq_pc         = in_pc + PcInc;
  assign dec_target     = dec_taken ? (seq_pc + in_offset) : seq_pc;
  assign dec_mispredict = dec_branch && (dec_taken != in_pred_taken);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (xfer) state_d = StFull;
      StFull:  if (out_ready && !xfer) state_d = StEmpty;
    endcase
    // Flush wins over everything, including a consumer that is not ready.
    if (flush) state_d = StEmpty;
  end

  always_comb begin
    cnt_br_d = cnt_br_q;
    cnt_mp_d = cnt_mp_q;
    if (xfer && dec_branch) begin
      if (cnt_br_q != CntMax) cnt_br_d = cnt_br_q + CntOne;
      if (dec_mispredict && (cnt_mp_q != CntMax)) cnt_mp_d = cnt_mp_q + CntOne;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StEmpty;
      cnt_br_q <= '0;
      cnt_mp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_br_q <= cnt_br_d;
      cnt_mp_q <= cnt_mp_d;
    end
  end

  // Result payload only loads on a transfer, so it stays stable across a stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_q     <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      target_q     <= '0;
    end else if (xfer) begin
      branch_q     <= dec_branch;
      taken_q      <= dec_taken;
      mispredict_q <= dec_mispredict;
      target_q     <= dec_target;
    end
  end

  assign out_branch      = branch_q;
  assign out_taken       = taken_q;
  assign out_mispredict  = mispredict_q;
  assign out_target      = target_q;
  assign cnt_branches    = cnt_br_q;
  assign cnt_mispredicts = cnt_mp_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed corner cases then randomized traffic
// compared against a behavioural model of the one-slot result buffer and statistics.
module tb_branch_resolve_unit;

  localparam int unsigned CntW   = 4;
  localparam int          CntMax = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  in_op;
  logic [31:0] in_rs, in_rt, in_pc, in_offset;
  logic        in_pred_taken, flush;
  logic        out_valid, out_ready, out_branch, out_taken, out_mispredict;
  logic [31:0] out_target;
  logic [CntW-1:0] cnt_branches, cnt_mispredicts;

  int n_asserts = 0;
  int n_fail    = 0;

  // Model state
  bit          m_valid;
  bit          m_br, m_tk, m_mp;
  logic [31:0] m_tgt;
  int          m_cb, m_cm;

  branch_resolve_unit #(
    .DATA_W(32), .ADDR_W(32), .CNT_W(CntW), .PC_INC(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_rs          (in_rs),
    .in_rt          (in_rt),
    .in_pc          (in_pc),
    .in_offset      (in_offset),
    .in_pred_taken  (in_pred_taken),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_branch     (out_branch),
    .out_taken      (out_taken),
    .out_target     (out_target),
    .out_mispredict (out_mispredict),
    .cnt_branches   (cnt_branches),
    .cnt_mispredicts(cnt_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural meaning of each op, written with signed arithmetic.
  task automatic ref_calc(input logic [4:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [31:0] pc, input logic [31:0] off, input logic pred,
                          output bit br, output bit tk, output logic [31:0] tgt,
                          output bit mp);
    int signed s;
    s  = $signed(rs);
    br = 1;
    case (op)
      5'd6:    tk = (rs == rt);
      5'd7:    tk = (rs != rt);
      5'd8:    tk = (s <= 0);
      5'd9:    tk = (s > 0);
      5'd10:   tk = (s >= 0);
      5'd11:   tk = (s < 0);
      default: begin br = 0; tk = 0; end
    endcase
    tgt = tk ? (pc + 32'd4 + off) : (pc + 32'd4);
    mp  = br && (tk != pred);
  endtask

  task automatic check_outputs();
    check("out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      check("out_branch", 64'(out_branch), 64'(m_br));
      check("out_taken", 64'(out_taken), 64'(m_tk));
      check("out_target", 64'(out_target), 64'(m_tgt));
      check("out_mispredict", 64'(out_mispredict), 64'(m_mp));
    end
    check("cnt_branches", 64'(cnt_branches), 64'(m_cb));
    check("cnt_mispredicts", 64'(cnt_mispredicts), 64'(m_cm));
  endtask

  task automatic check_reset_state();
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst out_branch", 64'(out_branch), 64'd0);
    check("rst out_taken", 64'(out_taken), 64'd0);
    check("rst out_target", 64'(out_target), 64'd0);
    check("rst out_mispredict", 64'(out_mispredict), 64'd0);
    check("rst cnt_branches", 64'(cnt_branches), 64'd0);
    check("rst cnt_mispredicts", 64'(cnt_mispredicts), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
  endtask

  // One clock cycle: drive, check in_ready, advance model, clock, check outputs.
  task automatic step(input bit v, input logic [4:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [31:0] pc, input logic [31:0] off,
                      input bit pred, input bit fl, input bit ordy);
    bit br, tk, mp, exp_rdy;
    logic [31:0] tgt;
    in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_pc = pc; in_offset = off;
    in_pred_taken = pred; flush = fl; out_ready = ordy;
    #1;
    exp_rdy = !fl && (!m_valid || ordy);
    check("in_ready", 64'(in_ready), 64'(exp_rdy));
    ref_calc(op, rs, rt, pc, off, pred, br, tk, tgt, mp);
    if (fl) begin
      m_valid = 0;
    end else if (v && exp_rdy) begin
      m_valid = 1; m_br = br; m_tk = tk; m_tgt = tgt; m_mp = mp;
      if (br && m_cb < CntMax) m_cb++;
      if (br && mp && m_cm < CntMax) m_cm++;
    end else if (ordy) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic model_reset();
    m_valid = 0; m_br = 0; m_tk = 0; m_mp = 0; m_tgt = '0; m_cb = 0; m_cm = 0;
  endtask

  initial begin
    logic [31:0] rs, rt;
    logic [4:0]  op;
    model_reset();
    rst = 1'b1; in_valid = 0; in_op = '0; in_rs = '0; in_rt = '0; in_pc = '0;
    in_offset = '0; in_pred_taken = 0; flush = 0; out_ready = 1;
    #3;
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // BEQ taken, predicted not taken
    step(1, 5'd6, 32'd5, 32'd5, 32'h100, 32'h20, 0, 0, 1);
    check("beq target", 64'(out_target), 64'h124);
    check("beq mispredict", 64'(out_mispredict), 64'd1);

    // Signed zero compares, back-to-back
    step(1, 5'd10, 32'h8000_0000, 32'd0, 32'h200, 32'h40, 0, 0, 1);
    check("bgez min taken", 64'(out_taken), 64'd0);
    step(1, 5'd8, 32'd0, 32'd0, 32'h204, 32'h40, 0, 0, 1);
    check("blez zero taken", 64'(out_taken), 64'd1);
    step(1, 5'd9, 32'd0, 32'd0, 32'h208, 32'h40, 0, 0, 1);
    check("bgtz zero taken", 64'(out_taken), 64'd0);
    step(1, 5'd11, 32'hFFFF_FFFF, 32'd0, 32'h20C, 32'hFFFF_FFF0, 1, 0, 1);
    check("bltz neg taken", 64'(out_taken), 64'd1);

    // Non-branch op with PC wrap
    step(1, 5'd0, 32'd1, 32'd2, 32'hFFFF_FFFC, 32'h10, 1, 0, 1);
    check("nonbranch target wrap", 64'(out_target), 64'd0);
    check("nonbranch branch", 64'(out_branch), 64'd0);

    // Stall 3 cycles with in_valid held, then release
    step(1, 5'd7, 32'd1, 32'd2, 32'h300, 32'h8, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 5'd6, 32'd9, 32'd9, 32'h400, 32'h8, 1, 0, 0);
    step(1, 5'd6, 32'd9, 32'd9, 32'h400, 32'h8, 1, 0, 1);
    check("post-stall target", 64'(out_target), 64'h40C);
    step(0, 5'd0, 32'd0, 32'd0, 32'h0, 32'h0, 0, 0, 1);

    // Flush while full with a pending input
    step(1, 5'd9, 32'd3, 32'd0, 32'h500, 32'h4, 0, 0, 0);
    step(1, 5'd9, 32'd3, 32'd0, 32'h600, 32'h4, 0, 1, 0);
    check("flush out_valid", 64'(out_valid), 64'd0);

    // 20 mispredicted branches saturate both counters
    for (int i = 0; i < 20; i++) step(1, 5'd6, 32'd7, 32'd7, 32'h700, 32'h4, 0, 0, 1);
    check("sat cnt_branches", 64'(cnt_branches), 64'd15);
    check("sat cnt_mispredicts", 64'(cnt_mispredicts), 64'd15);

    // Async reset in the middle of a stall
    step(1, 5'd7, 32'd1, 32'd2, 32'h800, 32'h4, 0, 0, 0);
    step(1, 5'd7, 32'd1, 32'd2, 32'h900, 32'h4, 0, 0, 0);
    #2;
    rst = 1'b1;
    in_valid = 0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;
    model_reset();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       rs = 32'd0;
        1:       rs = 32'h8000_0000 | $urandom;
        default: rs = $urandom;
      endcase
      rt = $urandom_range(0, 1) ? rs : $urandom;
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'($urandom_range(6, 11));
      step($urandom_range(0, 3) != 0, op, rs, rt, $urandom, $urandom,
           $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
